// File: rtl/collector_pkg.sv
// collector_pkg
// Shared definitions for the pipeline result collector: FSM state encoding,
// result width, default MISR feedback polynomial and the MISR step function.
package collector_pkg;

    localparam int RESULT_W = 8;

    // x^8 + x^4 + x^3 + x^2 + 1 with the x^8 term implied by the shift-out bit
    localparam logic [RESULT_W-1:0] DEFAULT_MISR_POLY = 8'h1D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } collector_state_t;

    // One MISR update: shift left, fold the outgoing MSB back through the
    // polynomial taps, then XOR in the new result.
    function automatic logic [RESULT_W-1:0] misr_step(
        input logic [RESULT_W-1:0] sig,
        input logic [RESULT_W-1:0] din,
        input logic [RESULT_W-1:0] poly
    );
        misr_step = {sig[RESULT_W-2:0], 1'b0} ^ (sig[RESULT_W-1] ? poly : '0) ^ din;
    endfunction

endpackage

// File: rtl/pipeline_result_collector_fifo.sv
// result_fifo
// Synchronous FIFO holding captured results for readback.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   clear      in   synchronous flush of pointers, count and rd_valid
//   push       in   write push_data (accepted when not full, or full with an accepted pop)
//   push_data  in   RESULT_W-bit data to store
//   pop        in   read request (accepted only when not empty)
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  entries held, $clog2(DEPTH)+1 bits
//   rd_data    out  registered data of the last accepted pop
//   rd_valid   out  high for one cycle after each accepted pop
//
// Read handshake: pop is a request without back-pressure; it is accepted at
// a clock edge only if the FIFO is non-empty at that edge. Each accepted pop
// produces rd_valid=1 with rd_data for exactly the following cycle; rd_data
// holds its last value when rd_valid is low.
module result_fifo
    import collector_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      push,
    input  logic [RESULT_W-1:0]       push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic [RESULT_W-1:0]       rd_data,
    output logic                      rd_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [RESULT_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // still accepted when paired with an accepted pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= do_pop;
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only observed after being written.
    always_ff @(posedge clock) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pipeline_result_collector.sv
// pipeline_result_collector
// Tracks operand launches (issue) through a fixed pipeline latency, captures
// the matching y result, buffers it in a FIFO, folds it into an 8-bit MISR
// and flags completion after NUM_SAMPLES results.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   start         in   one-cycle pulse, starts a run from IDLE or DONE
//   issue         in   operands launched into the pipeline this cycle
//   y             in   8-bit pipeline result
//   rd_en         in   pop one FIFO entry (allowed in every state)
//   rd_data       out  popped result, registered
//   rd_valid      out  rd_data valid, one cycle after an accepted pop
//   fifo_count    out  entries held
//   sample_count  out  results captured this run
//   signature     out  running MISR value
//   overflow      out  sticky: a capture was dropped on a full FIFO
//   done          out  high in DONE
//   busy          out  high in COLLECT or DRAIN
//
// The internal signal 'state' carries the FSM state for observation.
module pipeline_result_collector
    import collector_pkg::*;
#(
    parameter int                  LATENCY     = 2,
    parameter int                  DEPTH       = 8,
    parameter int                  NUM_SAMPLES = 8,
    parameter logic [RESULT_W-1:0] MISR_POLY   = DEFAULT_MISR_POLY
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    issue,
    input  logic [RESULT_W-1:0]     y,
    input  logic                    rd_en,
    output logic [RESULT_W-1:0]     rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [7:0]              sample_count,
    output logic [RESULT_W-1:0]     signature,
    output logic                    overflow,
    output logic                    done,
    output logic                    busy
);

    localparam logic [7:0] NUM = 8'(NUM_SAMPLES);

    collector_state_t     state;
    collector_state_t     state_next;
    logic                 start_ok;
    logic [7:0]           issued;
    logic [LATENCY-1:0]   vpipe;
    logic [LATENCY-1:0]   vpipe_next;
    logic                 issue_ok;
    logic                 capture;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push_drop;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                    start_ok   = 1'b1;
                end
            end
            COLLECT: begin
                busy = 1'b1;
                if (issued == NUM) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (sample_count == NUM) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = COLLECT;
                    start_ok   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- issue tracking ----------------
    assign issue_ok = (state == COLLECT) && issue && (issued < NUM);

    // Valid pipe: an accepted issue enters bit 0 and reaches the top bit
    // LATENCY-1 edges later, so it is seen at the LATENCY-th edge.
    if (LATENCY == 1) begin : g_pipe_single
        assign vpipe_next = issue_ok;
    end else begin : g_pipe_multi
        assign vpipe_next = {vpipe[LATENCY-2:0], issue_ok};
    end

    assign capture = ((state == COLLECT) || (state == DRAIN)) && vpipe[LATENCY-1];

    // A capture is lost only if the FIFO is full and no pop frees a slot.
    assign push_drop = capture && fifo_full && !(rd_en && !fifo_empty);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued       <= '0;
            vpipe        <= '0;
            sample_count <= '0;
            signature    <= '0;
            overflow     <= 1'b0;
        end else if (start_ok) begin
            issued       <= '0;
            vpipe        <= '0;
            sample_count <= '0;
            signature    <= '0;
            overflow     <= 1'b0;
        end else begin
            if (issue_ok) begin
                issued <= issued + 8'd1;
            end
            vpipe <= vpipe_next;
            if (capture) begin
                sample_count <= sample_count + 8'd1;
                signature    <= misr_step(signature, y, MISR_POLY);
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------- result buffer ----------------
    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_ok),
        .push      (capture),
        .push_data (y),
        .pop       (rd_en),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

endmodule
